spi_xfer_seq: RTL and testbench
===============================

SPI_XFER_SEQ -- requirements
Module: spi_xfer_seq

Interface
REQ-001 SHALL have no parameters; word width is fixed at 32 bits and chip-select width at 8 bits.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 divider  input  16  SCLK half-period in clk cycles, minus one.
REQ-005 cpol  input  1  idle level of sclk.
REQ-006 frame_words  input  8  words per frame, minus one.
REQ-007 cs_mask  input  8  slaves to select; active bits drive ss_n low.
REQ-008 cs_dly  input  8  CS setup/hold length, minus one; used only with the macro in REQ-030.
REQ-009 start, abort  input  1 each  frame start pulse; request to end the frame at the next word boundary.
REQ-010 wr_valid, wr_data  input  1, 32  TX word offer; wr_ready  output  1  TX word accepted.
REQ-011 rd_valid, rd_data  output  1, 32  RX word; rd_ready  input  1  RX word consumed.
REQ-012 se_latch, se_go  output  1 each; se_byte_sel  output  4; se_p_in  output  32; se_tip, se_last  input  1 each; se_p_out  input  32: shift-engine load/go/status/data.
REQ-013 pos_edge, neg_edge  output  1 each  single-cycle SCLK edge strobes; sclk  output  1  serial clock.
REQ-014 ss_n  output  8  active-low slave selects; busy  output  1; done  output  1  single-cycle frame-complete pulse.

Function
REQ-015 FSM states SHALL be IDLE, CS_SETUP, LOAD, GO, XFER, STORE, CS_HOLD.
REQ-016 IDLE: when start=1, SHALL latch cs_mask and frame_words, clear word_cnt, and go to CS_SETUP; start outside IDLE SHALL be ignored.
REQ-017 ss_n SHALL equal ~latched cs_mask in every state except IDLE, and 8'hFF in IDLE; busy SHALL be 1 outside IDLE.
REQ-018 LOAD: wr_ready=1; on wr_valid&&wr_ready, SHALL pulse se_latch with se_byte_sel=4'hF and se_p_in=wr_data, then go to GO.
REQ-019 GO: SHALL pulse se_go for exactly one cycle, then go to XFER.
REQ-020 XFER: divider counter counts 0..divider; on reaching divider it SHALL reset to 0 and toggle internal phase ph.
REQ-021 Edge strobes: pos_edge SHALL pulse in the cycle ph goes 0->1; neg_edge SHALL pulse in the cycle ph goes 1->0; sclk SHALL equal ph XOR cpol.
REQ-022 divider=0 SHALL give one edge per clk, i.e. an SCLK period of 2 clk cycles.
REQ-023 XFER exit: once se_tip has fallen and ph=0, SHALL go to STORE; the divider counter SHALL be cleared; no strobes outside XFER.
REQ-024 STORE: rd_valid=1 with rd_data=se_p_out captured on STORE entry; SHALL hold until rd_ready, with rd_data stable while rd_valid=1.
REQ-025 On the rd handshake: if word_cnt==latched frame_words or abort was seen, go to CS_HOLD; else increment word_cnt and go to LOAD.
REQ-026 abort seen in LOAD SHALL go to CS_HOLD without latching a word; abort during GO/XFER SHALL be registered and acted on at the STORE handshake.
REQ-027 CS_HOLD exit SHALL pulse done for one cycle and return to IDLE; ss_n SHALL be 8'hFF in that IDLE cycle.
REQ-028 If wr_valid and abort are both 1 in LOAD, abort SHALL win; wr_ready SHALL be 0 in that cycle.

Reset
REQ-029 rst SHALL immediately (asynchronously) force IDLE, with ph=0, counters 0, ss_n=8'hFF, sclk=cpol, and all other outputs 0 (rd_data=0); a frame in progress SHALL be dropped with no done.

Configuration
REQ-030 Macro SPI_XFER_SEQ_CS_DLY_EN:
- Defined: CS_SETUP SHALL last cs_dly+1 cycles before LOAD, and CS_HOLD SHALL last cs_dly+1 cycles before done.
- Undefined: CS_SETUP and CS_HOLD SHALL each last exactly 1 cycle, and cs_dly SHALL be ignored.

Verification
REQ-031 Macro undefined, divider=1, cpol=0, frame_words=0, cs_mask=8'h01, tx 32'hA5A5_0F0F -> ss_n=8'hFE; one se_latch; one se_go; sclk period 4 clk; rd_data=se_p_out; done once; ss_n=8'hFF after done.
REQ-032 frame_words=2, rd_ready low 10 cycles at word 1 -> 3 words sent; no edges while stalled; sclk held at cpol; ss_n low throughout.
REQ-033 Macro defined, cs_dly=3 -> exactly 4 cycles from ss_n low to wr_ready, and 4 cycles from last rd handshake to done.
REQ-034 abort pulse during XFER of word 0 of 4 -> word 0 completes and is stored; no word 1 is latched; done fires; second start during busy is ignored.
REQ-035 rst asserted mid-XFER -> ss_n=8'hFF and sclk=cpol without waiting for a clk edge; no done; a new frame afterwards works normally.
REQ-036 cpol=1, divider=0 -> sclk idles at 1, toggles every clk in XFER, and pos_edge/neg_edge alternate with no overlap.

Source files
------------

// File: rtl/spi_xfer_seq.sv
// SPI frame sequencer: chip-select framing, word hand-off to a shift engine, SCLK generation.
// Optional macro SPI_XFER_SEQ_CS_DLY_EN stretches CS setup/hold to cs_dly+1 cycles.
module spi_xfer_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] divider,
   input  logic        cpol,
   input  logic [7:0]  frame_words,
   input  logic [7:0]  cs_mask,
   input  logic [7:0]  cs_dly,
   input  logic        start,
   input  logic        abort,
   input  logic        wr_valid,
   input  logic [31:0] wr_data,
   output logic        wr_ready,
   output logic        rd_valid,
   output logic [31:0] rd_data,
   input  logic        rd_ready,
   output logic        se_latch,
   output logic        se_go,
   output logic [3:0]  se_byte_sel,
   output logic [31:0] se_p_in,
   input  logic        se_tip,
   input  logic        se_last,
   input  logic [31:0] se_p_out,
   output logic        pos_edge,
   output logic        neg_edge,
   output logic        sclk,
   output logic [7:0]  ss_n,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {IDLE, CS_SETUP, LOAD, GO, XFER, STORE, CS_HOLD} state_t;

   state_t      state_q, state_d;
   logic [7:0]  csMask_q, csMask_d;
   logic [7:0]  frameWords_q, frameWords_d;
   logic [7:0]  wordCnt_q, wordCnt_d;
   logic [15:0] divCnt_q, divCnt_d;
   logic        ph_q, ph_d;
   logic        tipSeen_q, tipSeen_d;
   logic        abortSeen_q, abortSeen_d;
   logic [31:0] rdData_q, rdData_d;
   logic        dlyDone;
   logic        tick;
   logic        exitXfer;
   logic        lastWord;
   logic        unusedBits;

`ifdef SPI_XFER_SEQ_CS_DLY_EN
   logic [7:0]  dlyCnt_q, dlyCnt_d;

   assign dlyDone    = (dlyCnt_q == cs_dly);
   assign unusedBits = se_last;

   always_comb begin
      dlyCnt_d = 8'd0;
      if ((state_q == CS_SETUP || state_q == CS_HOLD) && !dlyDone)
         dlyCnt_d = dlyCnt_q + 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) dlyCnt_q <= 8'd0;
      else     dlyCnt_q <= dlyCnt_d;
   end
`else
   assign dlyDone    = 1'b1;
   assign unusedBits = ^{se_last, cs_dly};
`endif

   // The word ends only after the engine has actually started and then dropped
   // tip, and never mid-period; the exit cycle itself must not emit an edge.
   assign exitXfer = (state_q == XFER) && tipSeen_q && !se_tip && !ph_q;
   assign tick     = (state_q == XFER) && !exitXfer && (divCnt_q == divider);
   assign lastWord = (wordCnt_q == frameWords_q) || abortSeen_q || abort;
   assign sclk     = ph_q ^ cpol;
   assign rd_data  = rdData_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (start) state_d = CS_SETUP;
         CS_SETUP: if (dlyDone) state_d = LOAD;
         LOAD: begin
            if (abort)         state_d = CS_HOLD;
            else if (wr_valid) state_d = GO;
         end
         GO:       state_d = XFER;
         XFER:     if (exitXfer) state_d = STORE;
         STORE:    if (rd_ready) state_d = lastWord ? CS_HOLD : LOAD;
         CS_HOLD:  if (dlyDone) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      csMask_d     = csMask_q;
      frameWords_d = frameWords_q;
      wordCnt_d    = wordCnt_q;
      abortSeen_d  = abortSeen_q;
      rdData_d     = rdData_q;
      divCnt_d     = 16'd0;
      ph_d         = 1'b0;
      tipSeen_d    = 1'b0;
      if (state_q == IDLE && start) begin
         csMask_d     = cs_mask;
         frameWords_d = frame_words;
         wordCnt_d    = 8'd0;
         abortSeen_d  = 1'b0;
      end
      if (state_q == GO || state_q == XFER)
         abortSeen_d = abortSeen_q | abort;
      if (state_q == XFER && !exitXfer) begin
         tipSeen_d = tipSeen_q | se_tip;
         if (tick) begin
            divCnt_d = 16'd0;
            ph_d     = ~ph_q;
         end else begin
            divCnt_d = divCnt_q + 16'd1;
            ph_d     = ph_q;
         end
      end
      if (exitXfer)
         rdData_d = se_p_out;
      if (state_q == STORE && rd_ready && !lastWord)
         wordCnt_d = wordCnt_q + 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csMask_q     <= 8'd0;
         frameWords_q <= 8'd0;
         wordCnt_q    <= 8'd0;
         divCnt_q     <= 16'd0;
         ph_q         <= 1'b0;
         tipSeen_q    <= 1'b0;
         abortSeen_q  <= 1'b0;
         rdData_q     <= 32'd0;
      end else begin
         csMask_q     <= csMask_d;
         frameWords_q <= frameWords_d;
         wordCnt_q    <= wordCnt_d;
         divCnt_q     <= divCnt_d;
         ph_q         <= ph_d;
         tipSeen_q    <= tipSeen_d;
         abortSeen_q  <= abortSeen_d;
         rdData_q     <= rdData_d;
      end
   end

   // Abort beats a simultaneous write offer in LOAD, so the word is never taken.
   always_comb begin
      wr_ready    = (state_q == LOAD) && !abort;
      se_latch    = wr_ready && wr_valid;
      se_byte_sel = se_latch ? 4'hF : 4'h0;
      se_p_in     = se_latch ? wr_data : 32'd0;
      se_go       = (state_q == GO);
      rd_valid    = (state_q == STORE);
      pos_edge    = tick && !ph_q;
      neg_edge    = tick && ph_q;
      ss_n        = (state_q == IDLE) ? 8'hFF : ~csMask_q;
      busy        = (state_q != IDLE);
      done        = (state_q == CS_HOLD) && dlyDone;
   end

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Directed self-checking bench for spi_xfer_seq with a behavioural 32-bit shift engine.
// Expected CS setup/hold length follows SPI_XFER_SEQ_CS_DLY_EN (cs_dly is driven to 3).
module tb_spi_xfer_seq;

`ifdef SPI_XFER_SEQ_CS_DLY_EN
   localparam int DlyCycles = 4;
`else
   localparam int DlyCycles = 1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] divider = 16'd1;
   logic        cpol = 1'b0;
   logic [7:0]  frame_words = 8'd0;
   logic [7:0]  cs_mask = 8'h01;
   logic [7:0]  cs_dly = 8'd3;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        wr_valid = 1'b1;
   logic [31:0] wr_data = 32'd0;
   logic        wr_ready;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        rd_ready = 1'b1;
   logic        se_latch, se_go;
   logic [3:0]  se_byte_sel;
   logic [31:0] se_p_in;
   logic        se_tip, se_last;
   logic [31:0] se_p_out;
   logic        pos_edge, neg_edge, sclk;
   logic [7:0]  ss_n;
   logic        busy, done;

   spi_xfer_seq dut (
      .clk(clk), .rst(rst), .divider(divider), .cpol(cpol),
      .frame_words(frame_words), .cs_mask(cs_mask), .cs_dly(cs_dly),
      .start(start), .abort(abort), .wr_valid(wr_valid), .wr_data(wr_data),
      .wr_ready(wr_ready), .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
      .se_latch(se_latch), .se_go(se_go), .se_byte_sel(se_byte_sel), .se_p_in(se_p_in),
      .se_tip(se_tip), .se_last(se_last), .se_p_out(se_p_out),
      .pos_edge(pos_edge), .neg_edge(neg_edge), .sclk(sclk),
      .ss_n(ss_n), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Shift engine model: 32 sclk periods per word, returns the inverted TX word.
   logic        tip;
   logic [5:0]  bitCnt;
   logic [31:0] txReg, pout;
   assign se_tip   = tip;
   assign se_last  = tip && (bitCnt == 6'd31);
   assign se_p_out = pout;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         tip    <= 1'b0;
         bitCnt <= 6'd0;
         txReg  <= 32'd0;
         pout   <= 32'd0;
      end else begin
         if (se_latch) txReg <= se_p_in;
         if (se_go) begin
            tip    <= 1'b1;
            bitCnt <= 6'd0;
         end else if (tip && neg_edge) begin
            bitCnt <= bitCnt + 6'd1;
            if (bitCnt == 6'd31) begin
               tip  <= 1'b0;
               pout <= ~txReg;
            end
         end
      end
   end

   logic [31:0] txWords [4];
   logic [31:0] rdWords [4];
   int checks = 0, errors = 0;
   int cyc = 0, latchCnt, goCnt, doneCnt, posCnt, negCnt, wrReadyCnt, rdCnt;
   int overlapCnt, altErr, lastEdge, lastPosCyc, period, ssBad, byteSelBad;
   int ssLowCyc, wrReadyCyc, lastHsCyc, doneCyc, stallWord, stallLeft, stallCyc, stallBad;
   logic prevSsIdle, wrReadySeen;
   logic [7:0] maskCur;

   // Monitor and host responder, sampled 1 ns after the falling edge.
   always @(negedge clk) begin
      #1;
      cyc++;
      if (se_latch) begin
         latchCnt++;
         if (se_byte_sel !== 4'hF) byteSelBad++;
      end else begin
         wr_data = txWords[latchCnt & 3];
      end
      if (se_go) goCnt++;
      if (done) begin
         doneCnt++;
         doneCyc = cyc;
      end
      if (wr_ready) begin
         wrReadyCnt++;
         if (!wrReadySeen) wrReadyCyc = cyc;
         wrReadySeen = 1'b1;
      end
      if (pos_edge && neg_edge) overlapCnt++;
      if (pos_edge) begin
         posCnt++;
         if (lastEdge == 1) altErr++;
         lastEdge = 1;
         if (lastPosCyc > 0) period = cyc - lastPosCyc;
         lastPosCyc = cyc;
      end
      if (neg_edge) begin
         negCnt++;
         if (lastEdge == 2) altErr++;
         lastEdge = 2;
      end
      if ((busy && ss_n !== ~maskCur) || (!busy && ss_n !== 8'hFF)) ssBad++;
      if (prevSsIdle && ss_n !== 8'hFF) ssLowCyc = cyc;
      prevSsIdle = (ss_n === 8'hFF);
      if (rd_valid && rdCnt == stallWord && stallLeft > 0) begin
         rd_ready = 1'b0;
         stallLeft--;
         stallCyc++;
         if (pos_edge || neg_edge || sclk !== cpol || ss_n === 8'hFF) stallBad++;
      end else begin
         rd_ready = 1'b1;
      end
      if (rd_valid && rd_ready) begin
         rdWords[rdCnt & 3] = rd_data;
         rdCnt++;
         lastHsCyc = cyc;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic clearStats();
      latchCnt = 0; goCnt = 0; doneCnt = 0; posCnt = 0; negCnt = 0; wrReadyCnt = 0;
      rdCnt = 0; overlapCnt = 0; altErr = 0; lastEdge = 0; lastPosCyc = 0; period = 0;
      ssBad = 0; byteSelBad = 0; ssLowCyc = 0; wrReadyCyc = 0; lastHsCyc = 0; doneCyc = 0;
      stallWord = -1; stallLeft = 0; stallCyc = 0; stallBad = 0;
      wrReadySeen = 1'b0; prevSsIdle = 1'b1;
      for (int i = 0; i < 4; i++) rdWords[i] = 32'd0;
      wr_data = txWords[0];
   endtask

   task automatic applyStimulus(input logic [7:0] fw, input logic [7:0] mask,
                                input logic [15:0] div, input logic pol);
      @(negedge clk);
      clearStats();
      frame_words = fw;
      cs_mask     = mask;
      maskCur     = mask;
      divider     = div;
      cpol        = pol;
      start       = 1'b1;
      @(negedge clk);
      start       = 1'b0;
   endtask

   task automatic waitDone(input string tag);
      int n = 0;
      while (doneCnt == 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      checkOutput(tag, (n >= 3000) ? 32'd1 : 32'd0, 32'd0);
   endtask

   initial begin
      txWords[0] = 32'hA5A5_0F0F;
      txWords[1] = 32'h1234_5678;
      txWords[2] = 32'hDEAD_BEEF;
      txWords[3] = 32'h0F1E_2D3C;
      maskCur = 8'h00;
      clearStats();

      // Reset state
      #12;
      checkOutput("rst_ss_n", {24'd0, ss_n}, 32'hFF);
      checkOutput("rst_sclk", {31'd0, sclk}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_done", {31'd0, done}, 32'd0);
      checkOutput("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      checkOutput("rst_rd_data", rd_data, 32'd0);
      checkOutput("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
      checkOutput("rst_se_go", {31'd0, se_go}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Single word, divider 1, cpol 0
      applyStimulus(8'd0, 8'h01, 16'd1, 1'b0);
      checkOutput("single_ss_low", {24'd0, ss_n}, 32'hFE);
      waitDone("single_timeout");
      checkOutput("single_latch", latchCnt, 1);
      checkOutput("single_go", goCnt, 1);
      checkOutput("single_period", period, 4);
      checkOutput("single_pos", posCnt, 32);
      checkOutput("single_neg", negCnt, 32);
      checkOutput("single_rd", rdWords[0], 32'h5A5A_F0F0);
      checkOutput("single_done", doneCnt, 1);
      checkOutput("single_ss_idle", {24'd0, ss_n}, 32'hFF);
      checkOutput("single_ss_track", ssBad, 0);
      checkOutput("single_bytesel", byteSelBad, 0);
      checkOutput("cs_setup_len", wrReadyCyc - ssLowCyc, DlyCycles);
      checkOutput("cs_hold_len", doneCyc - lastHsCyc, DlyCycles);

      // Three words, RX stalled 10 cycles on word 1
      applyStimulus(8'd2, 8'h24, 16'd1, 1'b0);
      stallWord = 1;
      stallLeft = 10;
      waitDone("stall_timeout");
      checkOutput("stall_latch", latchCnt, 3);
      checkOutput("stall_rdcnt", rdCnt, 3);
      checkOutput("stall_rd0", rdWords[0], 32'h5A5A_F0F0);
      checkOutput("stall_rd1", rdWords[1], 32'hEDCB_A987);
      checkOutput("stall_rd2", rdWords[2], 32'h2152_4110);
      checkOutput("stall_cycles", stallCyc, 10);
      checkOutput("stall_quiet", stallBad, 0);
      checkOutput("stall_ss_track", ssBad, 0);
      checkOutput("stall_done", doneCnt, 1);

      // Abort during word 0 of 4, plus a start pulse while busy
      applyStimulus(8'd3, 8'h80, 16'd1, 1'b0);
      while (posCnt < 5 && cyc < 100000) @(negedge clk);
      abort = 1'b1;
      start = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      waitDone("abort_timeout");
      checkOutput("abort_latch", latchCnt, 1);
      checkOutput("abort_rdcnt", rdCnt, 1);
      checkOutput("abort_rd0", rdWords[0], 32'h5A5A_F0F0);
      checkOutput("abort_done", doneCnt, 1);
      repeat (10) @(negedge clk);
      checkOutput("abort_no_restart", {31'd0, busy}, 32'd0);
      checkOutput("abort_done_once", doneCnt, 1);

      // Abort held in LOAD together with wr_valid
      abort = 1'b1;
      applyStimulus(8'd1, 8'h02, 16'd1, 1'b0);
      waitDone("load_abort_timeout");
      abort = 1'b0;
      checkOutput("load_abort_latch", latchCnt, 0);
      checkOutput("load_abort_wr_ready", wrReadyCnt, 0);
      checkOutput("load_abort_rdcnt", rdCnt, 0);
      checkOutput("load_abort_done", doneCnt, 1);

      // cpol 1, divider 0
      applyStimulus(8'd0, 8'h10, 16'd0, 1'b1);
      waitDone("fast_timeout");
      checkOutput("fast_period", period, 2);
      checkOutput("fast_pos", posCnt, 32);
      checkOutput("fast_neg", negCnt, 32);
      checkOutput("fast_overlap", overlapCnt, 0);
      checkOutput("fast_alternate", altErr, 0);
      checkOutput("fast_rd", rdWords[0], 32'h5A5A_F0F0);
      checkOutput("fast_sclk_idle", {31'd0, sclk}, 32'd1);

      // Asynchronous reset mid-transfer, then a normal frame
      applyStimulus(8'd1, 8'h08, 16'd0, 1'b1);
      while (posCnt < 7 && cyc < 100000) @(negedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      checkOutput("async_ss_n", {24'd0, ss_n}, 32'hFF);
      checkOutput("async_sclk", {31'd0, sclk}, 32'd1);
      checkOutput("async_busy", {31'd0, busy}, 32'd0);
      checkOutput("async_rd_valid", {31'd0, rd_valid}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("async_no_done", doneCnt, 0);
      applyStimulus(8'd0, 8'h01, 16'd1, 1'b0);
      waitDone("post_rst_timeout");
      checkOutput("post_rst_rd", rdWords[0], 32'h5A5A_F0F0);
      checkOutput("post_rst_done", doneCnt, 1);
      checkOutput("post_rst_period", period, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
